// File: rtl/ipf_lcu_feeder_if.sv
// Interface for the ipf_lcu_feeder image/parameter memory reads, the pixel
// stream into the filter, and the per-LCU side information.
// master: the feeder. slave: the memories and the filter.
interface ipf_lcu_feeder_if #(
  parameter int ADDR_W = 14,
  parameter int PRM_W  = 24
);
  logic              img_rd;
  logic [ADDR_W-1:0] img_addr;
  logic [7:0]        img_data;
  logic              prm_rd;
  logic [5:0]        prm_addr;
  logic [PRM_W-1:0]  prm_data;
  logic              busy;
  logic              in_en;
  logic [7:0]        din;
  logic [1:0]        ipf_type;
  logic [4:0]        ipf_band_pos;
  logic              ipf_wo_class;
  logic [15:0]       ipf_offset;
  logic [2:0]        lcu_x;
  logic [2:0]        lcu_y;
  logic [1:0]        lcu_size;

  modport master (
    output img_rd, img_addr,
    input  img_data,
    output prm_rd, prm_addr,
    input  prm_data,
    input  busy,
    output in_en, din,
    output ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
    output lcu_x, lcu_y, lcu_size
  );

  modport slave (
    input  img_rd, img_addr,
    output img_data,
    input  prm_rd, prm_addr,
    output prm_data,
    output busy,
    input  in_en, din,
    input  ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
    input  lcu_x, lcu_y, lcu_size
  );
endinterface

// File: rtl/ipf_lcu_feeder.sv
// ipf_lcu_feeder: walks an IMG_W x IMG_W 8-bit image LCU by LCU (LCU raster
// order, pixel raster order inside an LCU), fetches per-LCU filter parameters
// and streams pixels into the filter with the in_en/busy handshake.
// Optional feature macro: FEEDER_STALL_CNT_EN adds a saturating stall_cnt
// output counting SEND cycles with busy=1.
module ipf_lcu_feeder #(
  parameter int IMG_W  = 128,
  parameter int ADDR_W = 14,
  parameter int PRM_W  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            cfg_lcu_size,
  ipf_lcu_feeder_if.master      bus,
  output logic                  feed_active,
  output logic                  feed_done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int LOG_W = $clog2(IMG_W);
  localparam logic [2:0] NL16 = 3'(IMG_W / 16 - 1);
  localparam logic [2:0] NL32 = 3'(IMG_W / 32 - 1);
  localparam logic [2:0] NL64 = 3'(IMG_W / 64 - 1);

  typedef enum logic [2:0] {IDLE, PRM, PWAIT, FETCH, LOAD, SEND, DONE} state_t;

  state_t     state;
  logic [1:0] size_q;
  logic [2:0] cx, cy;
  logic [5:0] row, col;

  logic [2:0] log_s, idx_sh, n_last;
  logic [5:0] s_last, nxt_col, nxt_row;
  logic [2:0] nxt_cx, nxt_cy;
  logic       col_wrap, lcu_end, x_wrap, frame_end;

  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [2:0] x, input logic [2:0] y,
                                                   input logic [5:0] r, input logic [5:0] c,
                                                   input logic [2:0] sh);
    logic [ADDR_W-1:0] y_full, x_full;
    y_full = (ADDR_W'(y) << sh) + ADDR_W'(r);
    x_full = (ADDR_W'(x) << sh) + ADDR_W'(c);
    return (y_full << LOG_W) + x_full;
  endfunction

  function automatic logic [5:0] lcu_index(input logic [2:0] x, input logic [2:0] y,
                                           input logic [2:0] sh);
    return (6'(y) << sh) + 6'(x);
  endfunction

  // Size decode and next-position arithmetic for the pixel being accepted.
  always_comb begin
    case (size_q)
      2'd1:    begin s_last = 6'd31; n_last = NL32; log_s = 3'd5; end
      2'd2:    begin s_last = 6'd63; n_last = NL64; log_s = 3'd6; end
      default: begin s_last = 6'd15; n_last = NL16; log_s = 3'd4; end
    endcase
    idx_sh    = 3'(LOG_W) - log_s;
    col_wrap  = (col == s_last);
    lcu_end   = col_wrap && (row == s_last);
    x_wrap    = (cx == n_last);
    frame_end = lcu_end && x_wrap && (cy == n_last);
    nxt_col   = col_wrap ? '0 : col + 6'd1;
    nxt_row   = lcu_end ? '0 : (col_wrap ? row + 6'd1 : row);
    nxt_cx    = lcu_end ? (x_wrap ? '0 : cx + 3'd1) : cx;
    nxt_cy    = (lcu_end && x_wrap) ? cy + 3'd1 : cy;
  end

  // Frame walker FSM; every output is registered and set on entry to the
  // state that owns it, so read strobes/addresses for the next state are
  // computed from the post-advance position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      size_q           <= '0;
      cx               <= '0;
      cy               <= '0;
      row              <= '0;
      col              <= '0;
      bus.img_rd       <= 1'b0;
      bus.img_addr     <= '0;
      bus.prm_rd       <= 1'b0;
      bus.prm_addr     <= '0;
      bus.in_en        <= 1'b0;
      bus.din          <= '0;
      bus.ipf_type     <= '0;
      bus.ipf_band_pos <= '0;
      bus.ipf_wo_class <= 1'b0;
      bus.ipf_offset   <= '0;
      bus.lcu_x        <= '0;
      bus.lcu_y        <= '0;
      bus.lcu_size     <= '0;
      feed_active      <= 1'b0;
      feed_done        <= 1'b0;
`ifdef FEEDER_STALL_CNT_EN
      stall_cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          feed_done <= 1'b0;
          if (start) begin
            size_q       <= (cfg_lcu_size == 2'd3) ? 2'd0 : cfg_lcu_size;
            cx           <= '0;
            cy           <= '0;
            row          <= '0;
            col          <= '0;
            bus.prm_rd   <= 1'b1;
            bus.prm_addr <= '0;
            feed_active  <= 1'b1;
`ifdef FEEDER_STALL_CNT_EN
            stall_cnt    <= '0;
`endif
            state        <= PRM;
          end
        end
        PRM: begin
          bus.prm_rd <= 1'b0;
          state      <= PWAIT;
        end
        PWAIT: begin
          bus.ipf_type     <= bus.prm_data[23:22];
          bus.ipf_band_pos <= bus.prm_data[21:17];
          bus.ipf_wo_class <= bus.prm_data[16];
          bus.ipf_offset   <= bus.prm_data[15:0];
          bus.lcu_x        <= cx;
          bus.lcu_y        <= cy;
          bus.lcu_size     <= size_q;
          bus.img_rd       <= 1'b1;
          bus.img_addr     <= pixel_addr(cx, cy, row, col, log_s);
          state            <= FETCH;
        end
        FETCH: begin
          bus.img_rd <= 1'b0;
          state      <= LOAD;
        end
        LOAD: begin
          bus.din   <= bus.img_data;
          bus.in_en <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (bus.busy) begin
`ifdef FEEDER_STALL_CNT_EN
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
`endif
          end else begin
            bus.in_en <= 1'b0;
            col       <= nxt_col;
            row       <= nxt_row;
            cx        <= nxt_cx;
            cy        <= nxt_cy;
            if (frame_end) begin
              feed_done   <= 1'b1;
              feed_active <= 1'b0;
              state       <= DONE;
            end else if (lcu_end) begin
              bus.prm_rd   <= 1'b1;
              bus.prm_addr <= lcu_index(nxt_cx, nxt_cy, idx_sh);
              state        <= PRM;
            end else begin
              bus.img_rd   <= 1'b1;
              bus.img_addr <= pixel_addr(cx, cy, nxt_row, nxt_col, log_s);
              state        <= FETCH;
            end
          end
        end
        DONE: begin
          feed_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Self-checking bench for ipf_lcu_feeder: memory models, a scoreboard of
// expected pixels built at start, and directed frames (full size-64 frame,
// partial size-3 frame with stall and mid-frame start, reset mid-frame,
// restart with random busy). Honours FEEDER_STALL_CNT_EN.
module tb_ipf_lcu_feeder;

  typedef struct {
    logic [13:0] addr;
    logic [23:0] prm;
    logic [2:0]  lx;
    logic [2:0]  ly;
    logic [1:0]  sz;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] cfg_lcu_size;
  logic       feed_active;
  logic       feed_done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  ipf_lcu_feeder_if #(.ADDR_W(14), .PRM_W(24)) bus ();

  ipf_lcu_feeder #(.IMG_W(128), .ADDR_W(14), .PRM_W(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_lcu_size (cfg_lcu_size),
    .bus          (bus),
    .feed_active  (feed_active),
    .feed_done    (feed_done)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  logic [13:0] rd_log[$];
  logic [5:0]  prm_log[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [23:0] prm_word(input logic [5:0] i);
    if (i == 6'd0) return 24'hC52AF0;
    return {~i[1:0], i[4:0] ^ 5'h15, i[0], 4'hA, i, ~i};
  endfunction

  // Memory models: one-cycle read latency, every read logged.
  always @(posedge clk) begin
    if (bus.img_rd) begin
      bus.img_data <= bus.img_addr[7:0];
      rd_log.push_back(bus.img_addr);
    end
    if (bus.prm_rd) begin
      bus.prm_data <= prm_word(bus.prm_addr);
      prm_log.push_back(bus.prm_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_en"},    32'(bus.in_en), 32'd0);
    check({tag, "_din"},      32'(bus.din), 32'd0);
    check({tag, "_img_rd"},   32'(bus.img_rd), 32'd0);
    check({tag, "_img_addr"}, 32'(bus.img_addr), 32'd0);
    check({tag, "_prm_rd"},   32'(bus.prm_rd), 32'd0);
    check({tag, "_prm_addr"}, 32'(bus.prm_addr), 32'd0);
    check({tag, "_ipf"},      32'({bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class, bus.ipf_offset}), 32'd0);
    check({tag, "_lcu"},      32'({bus.lcu_x, bus.lcu_y, bus.lcu_size}), 32'd0);
    check({tag, "_active"},   32'(feed_active), 32'd0);
    check({tag, "_done"},     32'(feed_done), 32'd0);
`ifdef FEEDER_STALL_CNT_EN
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
  endtask

  // Runs one frame; stop_after=0 runs to feed_done, otherwise returns at the
  // negedge where the stop_after-th pixel is being handed over.
  task automatic run(input logic [1:0] cfg, input int unsigned stop_after,
                     input int unsigned stall_at, input bit poke, input bit rnd);
    int unsigned s, n, ss, accepted, cyc, done_cnt, stall_n, budget, exp_reads;
    logic [1:0]  szc;
    logic        prev_hold, seen_en;
    logic [7:0]  prev_din;
    logic [13:0] got;
    exp_t        e;
    logic [5:0]  exp_prm[$];

    s   = (cfg == 2'd1) ? 32 : (cfg == 2'd2) ? 64 : 16;
    szc = (cfg == 2'd3) ? 2'd0 : cfg;
    n   = 128 / s;
    ss  = s * s;
    sb.delete();
    for (int ly = 0; ly < int'(n); ly++)
      for (int lx = 0; lx < int'(n); lx++) begin
        exp_prm.push_back(6'(ly * int'(n) + lx));
        for (int r = 0; r < int'(s); r++)
          for (int c = 0; c < int'(s); c++) begin
            e.addr = 14'((ly * int'(s) + r) * 128 + lx * int'(s) + c);
            e.prm  = prm_word(6'(ly * int'(n) + lx));
            e.lx   = 3'(lx);
            e.ly   = 3'(ly);
            e.sz   = szc;
            sb.push_back(e);
          end
      end

    @(negedge clk);
    rd_log.delete();
    prm_log.delete();
    cfg_lcu_size = cfg;
    start        = 1'b1;
    bus.busy     = 1'b0;
    @(negedge clk);
    start        = 1'b0;
    cfg_lcu_size = ~cfg;
    check("first_prm_rd",   32'(bus.prm_rd), 32'd1);
    check("first_prm_addr", 32'(bus.prm_addr), 32'd0);
    check("active_on",      32'(feed_active), 32'd1);

    cyc = 1; accepted = 0; done_cnt = 0; stall_n = 0;
    prev_hold = 1'b0; seen_en = 1'b0; prev_din = '0;
    budget = 4 * ((stop_after != 0) ? stop_after : n * n * ss) + 1000;

    while (1) begin
      if (prev_hold) begin
        check("hold_in_en", 32'(bus.in_en), 32'd1);
        check("hold_din",   32'(bus.din), 32'(prev_din));
      end
      if (feed_done) done_cnt++;
      if (bus.in_en && stall_at != 0 && accepted == stall_at && stall_n < 5) begin
        bus.busy = 1'b1;
        stall_n++;
      end else begin
        bus.busy = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      if (bus.in_en) begin
        if (!seen_en) begin
          check("first_in_en_latency", cyc, 32'd5);
          seen_en = 1'b1;
        end
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb[0];
          check("din",        32'(bus.din), 32'(e.addr[7:0]));
          check("ipf_type",   32'(bus.ipf_type), 32'(e.prm[23:22]));
          check("band_pos",   32'(bus.ipf_band_pos), 32'(e.prm[21:17]));
          check("wo_class",   32'(bus.ipf_wo_class), 32'(e.prm[16]));
          check("offset",     32'(bus.ipf_offset), 32'(e.prm[15:0]));
          check("lcu_x",      32'(bus.lcu_x), 32'(e.lx));
          check("lcu_y",      32'(bus.lcu_y), 32'(e.ly));
          check("lcu_size",   32'(bus.lcu_size), 32'(e.sz));
          check("active_en",  32'(feed_active), 32'd1);
          if (!bus.busy) begin
            accepted++;
            check("img_reads_outstanding", 32'(rd_log.size()), 32'd1);
            if (rd_log.size() > 0) begin
              got = rd_log.pop_front();
              check("img_addr", 32'(got), 32'(e.addr));
            end
            void'(sb.pop_front());
          end
        end
      end
      prev_hold = bus.in_en && bus.busy;
      prev_din  = bus.din;
      start     = poke && (accepted == 300);
      if (stop_after != 0 && accepted == stop_after) break;
      if (stop_after == 0 && feed_done) break;
      if (cyc > budget) begin
        check("watchdog_cycles", cyc, budget);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;

    if (stop_after == 0) begin
      check("active_at_done", 32'(feed_active), 32'd0);
      check("pixels_per_frame", accepted, n * n * ss);
      check("sb_drained", 32'(sb.size()), 32'd0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (feed_done) done_cnt++;
      end
      check("feed_done_count", done_cnt, 32'd1);
    end
    exp_reads = (accepted == 0) ? 1 : (accepted - 1) / ss + 1;
    check("prm_read_count", 32'(prm_log.size()), exp_reads);
    for (int k = 0; k < prm_log.size(); k++)
      check("prm_addr_seq", 32'(prm_log[k]), 32'(exp_prm[k]));
`ifdef FEEDER_STALL_CNT_EN
    if (stall_at != 0) check("stall_cnt", 32'(stall_cnt), 32'd5);
`endif
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    cfg_lcu_size = 2'd0;
    bus.busy     = 1'b0;
    bus.img_data = '0;
    bus.prm_data = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    // Full frame, 64x64 LCUs, busy held low; LCU 0 carries 24'hC52AF0.
    run(2'd2, 0, 0, 1'b0, 1'b0);

    // Size code 3 behaves as 16: stall of 5 cycles at pixel 20, start poked
    // mid-frame, stopped after 1000 pixels (covers LCU(1,0) and row wrap).
    run(2'd3, 1000, 20, 1'b1, 1'b0);

    // Asynchronous reset mid-frame clears everything immediately.
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    check_outputs_zero("midreset_hold");
    reset = 1'b0;

    // Restart after reset with random backpressure.
    run(2'd0, 600, 0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
